filter_seq: RTL and testbench
=============================

# filter_seq

Parametrised frame sequencer that streams a block of samples from sample memory through an external filter core, one sample per core transaction, and writes each result to output memory. It replaces the fixed single-channel, fixed-delay sequencer: base address, length, channel count, memory settle delay and data width are all configurable. An optional watchdog aborts a frame when the core hangs. It sits between the sample/result RAMs and the filter core, under control of the top-level controller.

## Interface
Parameters:
- DATA_W, 32, sample/result width
- ADDR_W, 10, memory address width
- NCH, 1, channel count (≥1); CH_W = max(1, clog2(NCH))
- SETTLE, 2, memory read latency in cycles (≥1)
- TIMEOUT, 1024, watchdog limit in cycles (used only with the watchdog macro)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  frame request; accepted only while ready=1
- base_addr  in  ADDR_W  first sample address; sampled at accept
- len  in  ADDR_W+1  samples per channel; sampled at accept
- ready  out  1  idle, can accept start
- done  out  1  one-cycle pulse at end of frame (normal or aborted)
- err  out  1  sticky watchdog flag
- rd_addr  out  ADDR_W  sample memory address
- rd_ch  out  CH_W  sample memory channel select
- din  in  DATA_W  sample memory data, valid SETTLE cycles after rd_addr/rd_ch change
- core_start  out  1  one-cycle core start pulse
- core_din  out  DATA_W  sample to core, held from start until next issue
- core_ready  in  1  core can accept
- core_valid  in  1  core result valid
- core_y  in  DATA_W  core result
- wr_en  out  1  result write strobe, one cycle per sample
- wr_addr  out  ADDR_W  result address (equals rd_addr of that sample)
- wr_ch  out  CH_W  result channel
- dout  out  DATA_W  result data, held until next write

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_Y, WRITE, NEXT, DONE.
- IDLE: ready=1. start=1 latches base_addr, len, clears idx, ch, err; next state FETCH, or DONE if len=0.
- FETCH: rd_addr = base_addr + idx (mod 2^ADDR_W, wraps silently), rd_ch = ch; stays exactly SETTLE cycles.
- ISSUE: waits for core_ready; in the cycle it is seen, core_din <= din, core_start=1 for the following cycle only; go WAIT_Y.
- WAIT_Y: on core_valid, dout <= core_y, wr_addr/wr_ch <= current address/channel; go WRITE. core_valid outside WAIT_Y ignored.
- WRITE: wr_en=1 for exactly this cycle; go NEXT.
- NEXT: idx+1 < len → idx++, FETCH; else idx=0, ch+1 < NCH → ch++, FETCH; else DONE. Order: channel-outer, sample-inner.
- DONE: done=1 one cycle; go IDLE.
- start while ready=0 ignored. len is ADDR_W+1 bits so a full 2^ADDR_W frame is expressible; len > 2^ADDR_W clamps to 2^ADDR_W.

## Timing
- Reset: all outputs 0 (ready, done, err, core_start, wr_en, addresses, core_din, dout); state IDLE; ready rises the first cycle after rst deasserts.
- Reset mid-frame: abort immediately, no further wr_en, no done.
- Per sample, with core_ready already high: SETTLE (FETCH) + 1 (ISSUE) + core latency (WAIT_Y) + 1 (WRITE) + 1 (NEXT) cycles.
- start accepted at edge T → ready=0 at T+1, rd_addr=base_addr at T+1.
- len=0: done at T+2, no core_start, no wr_en.
- All outputs registered; no combinational path from any input to any output.

## Configuration
- FILTER_SEQ_WATCHDOG_EN defined: counter in WAIT_Y; after TIMEOUT cycles without core_valid, err <= 1, frame aborts to DONE (done pulses, no wr_en for the sample); err cleared on next accepted start.
- Not defined: err tied 0, WAIT_Y waits indefinitely, TIMEOUT unused.

## Test plan
- Reset: rst high 3 cycles mid-frame → all outputs 0, ready=1 one cycle after release, no done.
- Single channel: NCH=1, SETTLE=2, base=0, len=4, core latency 3 → 4 core_start, wr_en at addresses 0,1,2,3 with dout = core_y, single done, 8 cycles/sample.
- Wrap: ADDR_W=4, base=14, len=4 → rd_addr/wr_addr 14,15,0,1.
- Multi-channel: NCH=3, len=2 → (ch,addr) writes (0,b),(0,b+1),(1,b),(1,b+1),(2,b),(2,b+1); 6 wr_en total.
- Backpressure/boundaries: core_ready low 5 cycles in ISSUE → core_start delayed, core_din = sample at that address; len=0 → done at T+2, no writes; start while busy ignored.
- Watchdog (macro on, TIMEOUT=16): core_valid never asserted → err=1 and done 16 cycles into WAIT_Y, wr_en never asserted; next start clears err.

Source files
------------

// File: rtl/filter_seq.sv
// filter_seq: streams a sample frame through an external filter core into result memory.
// Optional core-hang watchdog enabled by defining FILTER_SEQ_WATCHDOG_EN.
module filter_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NCH = 1,
  parameter int SETTLE = 2,
  parameter int TIMEOUT = 1024,
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CH_W-1:0]   rd_ch,
  input  logic [DATA_W-1:0] din,
  output logic              core_start,
  output logic [DATA_W-1:0] core_din,
  input  logic              core_ready,
  input  logic              core_valid,
  input  logic [DATA_W-1:0] core_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH_W-1:0]   wr_ch,
  output logic [DATA_W-1:0] dout
);
  localparam int CNT_W = $clog2((SETTLE > TIMEOUT ? SETTLE : TIMEOUT) + 1);
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_Y, WRITE, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, idx_q, idx_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [CH_W-1:0] ch_q, ch_d, rd_ch_q, rd_ch_d, wr_ch_q, wr_ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] core_din_q, core_din_d, dout_q, dout_d;
  logic ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic core_start_q, core_start_d, wr_en_q, wr_en_d;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    idx_d = idx_q;
    ch_d = ch_q;
    core_din_d = core_din_q;
    dout_d = dout_q;
    wr_addr_d = wr_addr_q;
    wr_ch_d = wr_ch_q;
    err_d = err_q;
    core_start_d = 1'b0;
    case (state_q)
      IDLE: if (start && ready_q) begin
        base_d = base_addr;
        len_d = len[ADDR_W] ? LEN_MAX : len;
        idx_d = '0;
        ch_d = '0;
        err_d = 1'b0;
        state_d = len_d == '0 ? DONE : FETCH;
      end
      FETCH: state_d = cnt_q == CNT_W'(SETTLE - 1) ? ISSUE : FETCH;
      ISSUE: if (core_ready) begin
        core_din_d = din;
        core_start_d = 1'b1;
        state_d = WAIT_Y;
      end
      WAIT_Y: if (core_valid) begin
        dout_d = core_y;
        wr_addr_d = rd_addr_q;
        wr_ch_d = rd_ch_q;
        state_d = WRITE;
      end
`ifdef FILTER_SEQ_WATCHDOG_EN
      else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        err_d = 1'b1;
        state_d = DONE;
      end
`endif
      WRITE: state_d = NEXT;
      NEXT: if ({1'b0, idx_q} + 1'b1 < len_q) begin
        idx_d = idx_q + 1'b1;
        state_d = FETCH;
      end else if (int'(ch_q) + 1 < NCH) begin
        idx_d = '0;
        ch_d = ch_q + 1'b1;
        state_d = FETCH;
      end else begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // cnt measures time spent in the current state (settle and watchdog)
    cnt_d = state_d != state_q ? '0 : cnt_q + 1'b1;
    rd_addr_d = base_d + idx_d;
    rd_ch_d = ch_d;
    ready_d = state_d == IDLE;
    wr_en_d = state_d == WRITE;
    done_d = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      ch_q <= '0;
      cnt_q <= '0;
      rd_addr_q <= '0;
      rd_ch_q <= '0;
      wr_addr_q <= '0;
      wr_ch_q <= '0;
      core_din_q <= '0;
      dout_q <= '0;
      ready_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      core_start_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      idx_q <= idx_d;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_ch_q <= rd_ch_d;
      wr_addr_q <= wr_addr_d;
      wr_ch_q <= wr_ch_d;
      core_din_q <= core_din_d;
      dout_q <= dout_d;
      ready_q <= ready_d;
      done_q <= done_d;
      err_q <= err_d;
      core_start_q <= core_start_d;
      wr_en_q <= wr_en_d;
    end
  end
  assign ready = ready_q;
  assign done = done_q;
  assign err = err_q;
  assign rd_addr = rd_addr_q;
  assign rd_ch = rd_ch_q;
  assign core_start = core_start_q;
  assign core_din = core_din_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_ch = wr_ch_q;
  assign dout = dout_q;
endmodule

// File: tb/tb_filter_seq.sv
// tb_filter_seq: directed bench for filter_seq (ADDR_W=4, NCH=3, SETTLE=2, core latency 3).
module tb_filter_seq;
  logic clk = 0, rst = 1, start = 0, core_ready = 1, core_valid = 0, core_mute = 0, p1 = 0;
  logic [3:0] base_addr = 0, rd_addr, wr_addr;
  logic [4:0] len = 0;
  logic [1:0] rd_ch, wr_ch;
  logic [15:0] din = 0, d1 = 0, core_din, core_y = 0, cdat = 0, dout;
  logic ready, done, err, core_start, wr_en;
  int tests = 0, fails = 0, cyc = 0, n_wr = 0, n_cs = 0, n_done = 0, done_cyc = 0, cs_cyc = 0;
  logic [3:0] log_addr[512];
  logic [1:0] log_ch[512];
  logic [15:0] log_dout[512];
  int wr_cyc[512];

  always #5 clk = ~clk;

  filter_seq #(.DATA_W(16), .ADDR_W(4), .NCH(3), .SETTLE(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .ready(ready), .done(done), .err(err), .rd_addr(rd_addr), .rd_ch(rd_ch),
    .din(din), .core_start(core_start), .core_din(core_din), .core_ready(core_ready),
    .core_valid(core_valid), .core_y(core_y), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_ch(wr_ch), .dout(dout)
  );

  function automatic logic [15:0] mem(input logic [3:0] a, input logic [1:0] c);
    return {2'b00, c, 8'h3C, a};
  endfunction

  // sample RAM with 2-cycle read latency; core answers 3 cycles after its start pulse
  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1 <= mem(rd_addr, rd_ch);
    din <= d1;
    p1 <= core_start;
    if (core_start) cdat <= core_din ^ 16'h5A5A;
    core_valid <= p1 && !core_mute;
    core_y <= cdat;
  end

  always @(negedge clk) begin
    if (wr_en && n_wr < 512) begin
      log_addr[n_wr] = wr_addr;
      log_ch[n_wr] = wr_ch;
      log_dout[n_wr] = dout;
      wr_cyc[n_wr] = cyc;
      n_wr++;
    end
    if (core_start) begin
      cs_cyc = cyc;
      n_cs++;
    end
    if (done) begin
      done_cyc = cyc;
      n_done++;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] b, input logic [4:0] l, output int acc);
    int k = 0;
    while (!ready && k < 60) begin tick; k++; end
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL start_ready: ready=%b required 1", ready); end
    base_addr = b; len = l; start = 1;
    tick;
    start = 0;
    acc = cyc;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (n_done == d0 && k < budget) begin tick; k++; end
    tests++;
    if (n_done == d0) begin fails++; $display("FAIL done_timeout: no done within %0d cycles", budget); end
  endtask

  task automatic test_reset;
    int acc, d0, w1;
    rst = 1;
    repeat (3) tick;
    tests++;
    if ({ready, done, err, core_start, wr_en} !== 5'b0 || {rd_addr, wr_addr, rd_ch, wr_ch} !== 12'b0 || {core_din, dout} !== 32'b0) begin
      fails++; $display("FAIL reset_outputs: ctl=%b rd=%h wr=%h din=%h dout=%h required all 0", {ready, done, err, core_start, wr_en}, rd_addr, wr_addr, core_din, dout);
    end
    rst = 0;
    tick;
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: ready=%b required 1", ready); end
    start_frame(4'd0, 5'd4, acc);
    repeat (12) tick;
    d0 = n_done;
    rst = 1;
    repeat (3) tick;
    tests++;
    if ({ready, done, core_start, wr_en} !== 4'b0 || core_din !== 16'h0 || dout !== 16'h0 || rd_addr !== 4'h0) begin
      fails++; $display("FAIL reset_midframe: ctl=%b din=%h dout=%h rd=%h required all 0", {ready, done, core_start, wr_en}, core_din, dout, rd_addr);
    end
    w1 = n_wr;
    rst = 0;
    tick;
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: ready=%b required 1", ready); end
    repeat (30) tick;
    tests++;
    if (n_wr != w1 || n_done != d0) begin
      fails++; $display("FAIL reset_quiet: writes=%0d done=%0d after abort, required 0 and 0", n_wr - w1, n_done - d0);
    end
  endtask

  task automatic test_single_frame;
    int acc, w0 = n_wr, c0 = n_cs, d0 = n_done;
    logic [3:0] ea;
    logic [1:0] ec;
    start_frame(4'd2, 5'd4, acc);
    tests++;
    if (ready !== 1'b0 || rd_addr !== 4'd2 || rd_ch !== 2'd0) begin
      fails++; $display("FAIL accept: ready=%b rd_addr=%0d rd_ch=%0d required 0 2 0", ready, rd_addr, rd_ch);
    end
    wait_done(d0, 400);
    tick;
    tests++;
    if (n_wr - w0 != 12 || n_cs - c0 != 12 || n_done - d0 != 1) begin
      fails++; $display("FAIL frame_counts: wr=%0d cs=%0d done=%0d required 12 12 1", n_wr - w0, n_cs - c0, n_done - d0);
    end
    tests++;
    if (wr_cyc[w0] != acc + 6 || wr_cyc[w0+1] - wr_cyc[w0] != 8) begin
      fails++; $display("FAIL frame_timing: first=%0d gap=%0d required %0d 8", wr_cyc[w0] - acc, wr_cyc[w0+1] - wr_cyc[w0], 6);
    end
    for (int k = 0; k < 12; k++) begin
      ea = 4'd2 + 4'(k % 4);
      ec = 2'(k / 4);
      tests++;
      if (log_addr[w0+k] !== ea || log_ch[w0+k] !== ec || log_dout[w0+k] !== (mem(ea, ec) ^ 16'h5A5A)) begin
        fails++; $display("FAIL frame_write%0d: ch=%0d addr=%0d dout=%h required %0d %0d %h", k, log_ch[w0+k], log_addr[w0+k], log_dout[w0+k], ec, ea, mem(ea, ec) ^ 16'h5A5A);
      end
    end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_idle: err=%b required 0", err); end
  endtask

  task automatic test_wrap;
    int acc, w0 = n_wr, d0 = n_done;
    logic [3:0] exp_a[4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    start_frame(4'd14, 5'd4, acc);
    wait_done(d0, 400);
    tests++;
    if (n_wr - w0 != 12) begin fails++; $display("FAIL wrap_count: wr=%0d required 12", n_wr - w0); end
    for (int k = 0; k < 12; k++) begin
      tests++;
      if (log_addr[w0+k] !== exp_a[k%4] || log_ch[w0+k] !== 2'(k / 4)) begin
        fails++; $display("FAIL wrap_write%0d: ch=%0d addr=%0d required %0d %0d", k, log_ch[w0+k], log_addr[w0+k], k / 4, exp_a[k%4]);
      end
    end
  endtask

  task automatic test_multi_channel;
    int acc, w0 = n_wr, d0 = n_done;
    logic [3:0] exp_a[6] = '{4'd5, 4'd6, 4'd5, 4'd6, 4'd5, 4'd6};
    logic [1:0] exp_c[6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    start_frame(4'd5, 5'd2, acc);
    wait_done(d0, 200);
    tests++;
    if (n_wr - w0 != 6) begin fails++; $display("FAIL multi_count: wr=%0d required 6", n_wr - w0); end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (log_addr[w0+k] !== exp_a[k] || log_ch[w0+k] !== exp_c[k] || log_dout[w0+k] !== (mem(exp_a[k], exp_c[k]) ^ 16'h5A5A)) begin
        fails++; $display("FAIL multi_write%0d: ch=%0d addr=%0d dout=%h required %0d %0d", k, log_ch[w0+k], log_addr[w0+k], log_dout[w0+k], exp_c[k], exp_a[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    int acc, w0 = n_wr, c0 = n_cs, d0 = n_done;
    core_ready = 0;
    start_frame(4'd3, 5'd1, acc);
    repeat (7) tick;
    core_ready = 1;
    tick;
    tests++;
    if (core_start !== 1'b1 || n_cs - c0 != 1 || core_din !== mem(4'd3, 2'd0)) begin
      fails++; $display("FAIL bp_issue: core_start=%b starts=%0d core_din=%h required 1 1 %h", core_start, n_cs - c0, core_din, mem(4'd3, 2'd0));
    end
    wait_done(d0, 200);
    tests++;
    if (n_wr - w0 != 3 || log_dout[w0] !== (mem(4'd3, 2'd0) ^ 16'h5A5A) || log_ch[w0+2] !== 2'd2) begin
      fails++; $display("FAIL bp_writes: wr=%0d dout0=%h ch2=%0d required 3 %h 2", n_wr - w0, log_dout[w0], log_ch[w0+2], mem(4'd3, 2'd0) ^ 16'h5A5A);
    end
  endtask

  task automatic test_len_zero;
    int acc, w0 = n_wr, c0 = n_cs, d0 = n_done;
    start_frame(4'd7, 5'd0, acc);
    wait_done(d0, 20);
    repeat (5) tick;
    tests++;
    if (done_cyc != acc + 1 || n_wr != w0 || n_cs != c0 || n_done - d0 != 1) begin
      fails++; $display("FAIL len_zero: done_at=+%0d wr=%0d cs=%0d done=%0d required +1 0 0 1", done_cyc - acc, n_wr - w0, n_cs - c0, n_done - d0);
    end
  endtask

  task automatic test_back_to_back;
    int acc, w0 = n_wr, d0 = n_done;
    start_frame(4'd8, 5'd1, acc);
    repeat (4) tick;
    base_addr = 4'd0; len = 5'd2; start = 1;
    repeat (3) tick;
    start = 0;
    wait_done(d0, 200);
    tests++;
    if (n_wr - w0 != 3 || log_addr[w0] !== 4'd8 || log_addr[w0+2] !== 4'd8 || n_done - d0 != 1) begin
      fails++; $display("FAIL busy_start: wr=%0d addr0=%0d addr2=%0d done=%0d required 3 8 8 1", n_wr - w0, log_addr[w0], log_addr[w0+2], n_done - d0);
    end
    w0 = n_wr; d0 = n_done;
    start_frame(4'd9, 5'd1, acc);
    tests++;
    if (acc != done_cyc + 1) begin fails++; $display("FAIL b2b_accept: accepted at done+%0d required done+1", acc - done_cyc); end
    wait_done(d0, 200);
    tests++;
    if (n_wr - w0 != 3 || log_addr[w0+1] !== 4'd9 || log_ch[w0+1] !== 2'd1) begin
      fails++; $display("FAIL b2b_writes: wr=%0d addr1=%0d ch1=%0d required 3 9 1", n_wr - w0, log_addr[w0+1], log_ch[w0+1]);
    end
  endtask

  task automatic test_len_clamp;
    int acc, w0 = n_wr, d0 = n_done;
    start_frame(4'd0, 5'd20, acc);
    wait_done(d0, 1000);
    tests++;
    if (n_wr - w0 != 48 || log_addr[w0+15] !== 4'd15 || log_addr[w0+16] !== 4'd0 || log_ch[w0+16] !== 2'd1 || log_ch[w0+47] !== 2'd2) begin
      fails++; $display("FAIL len_clamp: wr=%0d a15=%0d a16=%0d c16=%0d c47=%0d required 48 15 0 1 2", n_wr - w0, log_addr[w0+15], log_addr[w0+16], log_ch[w0+16], log_ch[w0+47]);
    end
  endtask

`ifdef FILTER_SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    int acc, w0 = n_wr, c0 = n_cs, d0 = n_done;
    core_mute = 1;
    start_frame(4'd0, 5'd2, acc);
    wait_done(d0, 200);
    tests++;
    if (err !== 1'b1 || n_wr != w0 || n_cs - c0 != 1 || done_cyc != cs_cyc + 17) begin
      fails++; $display("FAIL watchdog: err=%b wr=%0d cs=%0d done_after_wait=%0d required 1 0 1 17", err, n_wr - w0, n_cs - c0, done_cyc - cs_cyc);
    end
    core_mute = 0;
    w0 = n_wr; d0 = n_done;
    start_frame(4'd1, 5'd1, acc);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL watchdog_clear: err=%b required 0", err); end
    wait_done(d0, 200);
    tests++;
    if (n_wr - w0 != 3 || err !== 1'b0) begin fails++; $display("FAIL watchdog_recover: wr=%0d err=%b required 3 0", n_wr - w0, err); end
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_wrap;
    test_multi_channel;
    test_backpressure;
    test_len_zero;
    test_back_to_back;
    test_len_clamp;
`ifdef FILTER_SEQ_WATCHDOG_EN
    test_watchdog;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
